// File: rtl/valid_array_flush_pkg.sv
// Shared cache parameters and valid-array flush FSM encodings.
// Imported by the valid-bit store and its priority encoder. The tag and data
// arrays use the same geometry defaults.
package valid_array_flush_pkg;

  localparam int DEF_NUM_SETS = 16;
  localparam int DEF_NUM_WAYS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/valid_array_flush_enc.sv
// first_zero_enc: combinational priority encoder for way allocation.
//   vec_i      : way valid vector, bit i = way i
//   free_idx_o : lowest way index whose bit is 0 (0 when every bit is 1)
//   all_ones_o : every way is valid, so there is no free way
module first_zero_enc
  import valid_array_flush_pkg::*;
#(
  parameter  int NUM_WAYS = DEF_NUM_WAYS,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] vec_i,
  output logic [WAY_W-1:0]    free_idx_o,
  output logic                all_ones_o
);

  // Scan from the top down so the lowest zero is the last one written.
  always_comb begin
    free_idx_o = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!vec_i[i]) free_idx_o = WAY_W'(i);
    end
    all_ones_o = &vec_i;
  end

endmodule

// File: rtl/valid_array_flush.sv
// valid_array_flush: NUM_SETS x NUM_WAYS valid-bit store for the cache.
//   clk, reset             : clock and synchronous active-low reset
//   wr_en/wr_set/wr_way/wr_val : single-bit write, dropped while flushing
//   rd_en/rd_set           : sample one set; results appear one cycle later
//   rd_valid/rd_free_way/rd_all_valid : registered read of the sampled set
//   flush_req              : start a flash invalidate, one set per cycle
//   flush_busy/flush_done  : flush in progress / one-cycle completion pulse
module valid_array_flush
  import valid_array_flush_pkg::*;
#(
  parameter  int NUM_SETS = DEF_NUM_SETS,
  parameter  int NUM_WAYS = DEF_NUM_WAYS,
  localparam int SET_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [SET_W-1:0]    wr_set,
  input  logic [WAY_W-1:0]    wr_way,
  input  logic                wr_val,
  input  logic                rd_en,
  input  logic [SET_W-1:0]    rd_set,
  output logic [NUM_WAYS-1:0] rd_valid,
  output logic [WAY_W-1:0]    rd_free_way,
  output logic                rd_all_valid,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                flush_done
);

  flush_state_e        state_q, state_d;
  logic [SET_W-1:0]    ptr_q, ptr_d;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] rd_valid_q, rd_valid_d;
  logic [WAY_W-1:0]    rd_free_way_q, rd_free_way_d;
  logic                rd_all_valid_q, rd_all_valid_d;

  logic                wr_ok;
  logic [NUM_WAYS-1:0] rd_vec;
  logic [WAY_W-1:0]    enc_free;
  logic                enc_all;

  // The busy and done flags are decoded straight from the state register.
  assign flush_busy = (state_q == ST_CLEAR);
  assign flush_done = (state_q == ST_DONE);
  // A way index beyond NUM_WAYS (non power-of-two way counts) is ignored.
  assign wr_ok      = wr_en && !flush_busy && (int'(wr_way) < NUM_WAYS);

  // Flush sequencer. The pointer stops at the last set instead of wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == SET_W'(NUM_SETS - 1)) state_d = ST_DONE;
        else                               ptr_d   = ptr_q + SET_W'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Array update: one bit write when idle, a whole-set clear while flushing.
  always_comb begin
    valid_d = valid_q;
    if (wr_ok)      valid_d[wr_set][wr_way] = wr_val;
    if (flush_busy) valid_d[ptr_q]          = '0;
  end

  // Read path: forward a same-edge write into the sampled set, and report an
  // empty set while a flush is in progress.
  always_comb begin
    rd_vec = valid_q[rd_set];
    if (wr_ok && (wr_set == rd_set)) rd_vec[wr_way] = wr_val;
    if (flush_busy)                  rd_vec = '0;
  end

  first_zero_enc #(.NUM_WAYS(NUM_WAYS)) u_enc (
    .vec_i      (rd_vec),
    .free_idx_o (enc_free),
    .all_ones_o (enc_all)
  );

  always_comb begin
    rd_valid_d     = rd_valid_q;
    rd_free_way_d  = rd_free_way_q;
    rd_all_valid_d = rd_all_valid_q;
    if (rd_en) begin
      rd_valid_d     = rd_vec;
      rd_free_way_d  = enc_free;
      rd_all_valid_d = enc_all;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      rd_valid_q     <= '0;
      rd_free_way_q  <= '0;
      rd_all_valid_q <= '0;
      // NOTE: these valid bits are plain flops, not SRAM, so reset clears them all; a stale 1 would be a false hit.
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      rd_valid_q     <= rd_valid_d;
      rd_free_way_q  <= rd_free_way_d;
      rd_all_valid_q <= rd_all_valid_d;
      valid_q        <= valid_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_free_way  = rd_free_way_q;
  assign rd_all_valid = rd_all_valid_q;

endmodule

// File: tb/tb_valid_array_flush.sv
// Self-checking bench for valid_array_flush (16 sets x 4 ways).
module tb_valid_array_flush;

  localparam int NS = 16;
  localparam int NW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_set = '0;
  logic [1:0] wr_way = '0;
  logic       wr_val = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_set = '0;
  logic [3:0] rd_valid;
  logic [1:0] rd_free_way;
  logic       rd_all_valid;
  logic       flush_req = 1'b0;
  logic       flush_busy;
  logic       flush_done;

  valid_array_flush #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_set       (wr_set),
    .wr_way       (wr_way),
    .wr_val       (wr_val),
    .rd_en        (rd_en),
    .rd_set       (rd_set),
    .rd_valid     (rd_valid),
    .rd_free_way  (rd_free_way),
    .rd_all_valid (rd_all_valid),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .flush_done   (flush_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] v;
    logic [1:0] f;
    logic       a;
  } rd_exp_t;

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_set;
    logic [1:0] wr_way;
    logic       wr_val;
    logic       rd_en;
    logic [3:0] rd_set;
    rd_exp_t    exp;
  } vec_t;

  rd_exp_t sb_exp[$];
  string   sb_tag[$];
  int      n_checks = 0;
  int      n_err    = 0;
  vec_t    vecs[14];
  int      done_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [3:0] v, input logic [1:0] f, input logic a);
    rd_exp_t e;
    e.v = v; e.f = f; e.a = a;
    sb_exp.push_back(e);
    sb_tag.push_back(tag);
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge and any
  // read result expected at this edge is popped from the scoreboard.
  task automatic tick();
    rd_exp_t e;
    string   t;
    @(posedge clk);
    #1;
    if (sb_exp.size() != 0) begin
      e = sb_exp.pop_front();
      t = sb_tag.pop_front();
      check(t, {25'b0, rd_valid, rd_free_way, rd_all_valid}, {25'b0, e});
    end
  endtask

  task automatic do_write(input int s, input int w, input logic v);
    wr_en = 1'b1; wr_set = 4'(s); wr_way = 2'(w); wr_val = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input int s, input logic [3:0] v,
                         input logic [1:0] f, input logic a);
    rd_en = 1'b1; rd_set = 4'(s);
    push_exp(tag, v, f, a);
    tick();
    rd_en = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input int ws, input int ww, input logic wv,
                              input logic re, input int rs, input logic [3:0] v,
                              input int f, input logic a);
    vec_t r;
    r.wr_en = we; r.wr_set = 4'(ws); r.wr_way = 2'(ww); r.wr_val = wv;
    r.rd_en = re; r.rd_set = 4'(rs);
    r.exp.v = v; r.exp.f = 2'(f); r.exp.a = a;
    return r;
  endfunction

  initial begin
    // Each row: write fields, read fields, read outputs expected after the edge.
    vecs[0]  = mk(0, 0,  0, 0, 1, 5,  4'b0000, 0, 0);
    vecs[1]  = mk(1, 3,  0, 1, 0, 0,  4'b0000, 0, 0);
    vecs[2]  = mk(1, 3,  1, 1, 0, 0,  4'b0000, 0, 0);
    vecs[3]  = mk(1, 3,  2, 1, 1, 3,  4'b0111, 3, 0);
    vecs[4]  = mk(1, 3,  3, 1, 0, 0,  4'b0111, 3, 0);
    vecs[5]  = mk(0, 0,  0, 0, 1, 3,  4'b1111, 0, 1);
    vecs[6]  = mk(1, 7,  0, 1, 0, 0,  4'b1111, 0, 1);
    vecs[7]  = mk(1, 7,  2, 1, 1, 7,  4'b0101, 1, 0);
    vecs[8]  = mk(1, 3,  1, 0, 1, 3,  4'b1101, 1, 0);
    vecs[9]  = mk(0, 0,  0, 0, 1, 7,  4'b0101, 1, 0);
    vecs[10] = mk(1, 15, 1, 1, 1, 15, 4'b0010, 0, 0);
    vecs[11] = mk(0, 0,  0, 0, 1, 3,  4'b1101, 1, 0);
    vecs[12] = mk(1, 3,  0, 0, 1, 2,  4'b0000, 0, 0);
    vecs[13] = mk(0, 0,  0, 0, 1, 3,  4'b1100, 0, 0);

    // Reset state.
    reset = 1'b0;
    tick(); tick();
    check("reset_rd", {25'b0, rd_valid, rd_free_way, rd_all_valid}, 32'd0);
    check("reset_flags", {30'b0, flush_busy, flush_done}, 32'd0);
    reset = 1'b1;
    tick();

    // Table-driven write/read vectors, including same-edge forwarding and hold.
    for (int i = 0; i < 14; i++) begin
      wr_en = vecs[i].wr_en; wr_set = vecs[i].wr_set;
      wr_way = vecs[i].wr_way; wr_val = vecs[i].wr_val;
      rd_en = vecs[i].rd_en; rd_set = vecs[i].rd_set;
      push_exp($sformatf("vec%0d", i), vecs[i].exp.v, vecs[i].exp.f, vecs[i].exp.a);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Fill every set, then flush.
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) do_write(s, w, 1'b1);
    do_read("fill_set9", 9, 4'b1111, 2'd0, 1'b1);

    flush_req = 1'b1;
    tick();                                   // edge N
    flush_req = 1'b0;
    check("flush_start", {30'b0, flush_busy, flush_done}, 32'b10);
    for (int k = 1; k <= NS; k++) begin
      if (k == 4) begin                       // read of a still-full set while busy
        rd_en = 1'b1; rd_set = 4'd9;
        push_exp("rd_during_flush", 4'b0000, 2'd0, 1'b0);
      end
      if (k == 5) begin                       // write to an already-cleared set
        wr_en = 1'b1; wr_set = 4'd0; wr_way = 2'd1; wr_val = 1'b1;
      end
      if (k == 6) flush_req = 1'b1;           // ignored in CLEAR
      tick();                                 // edge N+k
      rd_en = 1'b0; wr_en = 1'b0; flush_req = 1'b0;
      if (k < NS) check($sformatf("flush_cyc%0d", k), {30'b0, flush_busy, flush_done}, 32'b10);
      else        check("flush_done_pulse", {30'b0, flush_busy, flush_done}, 32'b01);
    end
    // Write accepted in the DONE cycle.
    do_write(5, 3, 1'b1);                     // edge N+17
    check("after_done", {30'b0, flush_busy, flush_done}, 32'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("no_reflush%0d", k), {30'b0, flush_busy, flush_done}, 32'b00);
    end
    for (int s = 0; s < NS; s++)
      do_read($sformatf("post_flush_set%0d", s), s, (s == 5) ? 4'b1000 : 4'b0000, 2'd0, 1'b0);

    // Reset in the middle of a flush.
    do_write(4, 2, 1'b1);
    for (int w = 0; w < NW; w++) do_write(12, w, 1'b1);
    do_read("pre_abort_set12", 12, 4'b1111, 2'd0, 1'b1);
    flush_req = 1'b1;
    tick();                                   // edge N
    flush_req = 1'b0;
    repeat (4) tick();                        // edges N+1..N+4
    reset = 1'b0;
    tick();                                   // edge N+5
    reset = 1'b1;
    check("abort_flags", {30'b0, flush_busy, flush_done}, 32'b00);
    check("abort_rd", {25'b0, rd_valid, rd_free_way, rd_all_valid}, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (flush_done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    for (int s = 0; s < NS; s++)
      do_read($sformatf("post_abort_set%0d", s), s, 4'b0000, 2'd0, 1'b0);
    // A fresh flush must start straight away, so the sequencer is idle.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("reflush_start", {30'b0, flush_busy, flush_done}, 32'b10);
    repeat (NS) tick();
    check("reflush_done", {30'b0, flush_busy, flush_done}, 32'b01);
    tick();

    check("sb_drained", 32'(sb_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/valid_array_flush.md
Name: valid_array_flush

Overview:
Parametrised valid-bit store for the set-associative cache: NUM_SETS x NUM_WAYS valid bits replace the per-line single-bit valid flops. Provides a registered per-set read of all way valid bits, a lowest-free-way hint for allocation, a single-bit write port, and a sequenced flash-invalidate that clears one set per cycle. Sits beside the tag/data arrays; the cache controller drives writes on line fill/invalidate and uses flush for cache-wide invalidation.

Parameters:
NUM_SETS, 16, number of sets; power of two, >= 2
NUM_WAYS, 4, ways per set; >= 2
SET_W, $clog2(NUM_SETS), set index width (derived localparam, not overridden)
WAY_W, $clog2(NUM_WAYS), way index width (derived localparam, not overridden)

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-low reset
wr_en  in  1  write one valid bit this cycle
wr_set  in  SET_W  set index for write
wr_way  in  WAY_W  way index for write
wr_val  in  1  value written (1 = fill, 0 = invalidate line)
rd_en  in  1  sample set for read
rd_set  in  SET_W  set index for read
rd_valid  out  NUM_WAYS  registered valid vector of the read set, bit i = way i
rd_free_way  out  WAY_W  lowest way index with valid = 0 in rd_valid
rd_all_valid  out  1  all ways of the read set valid (no free way)
flush_req  in  1  request full invalidate
flush_busy  out  1  flush in progress; writes ignored
flush_done  out  1  one-cycle pulse when flush completes

Behaviour:
- Reset (reset == 0 at posedge): all array bits 0, rd_valid 0, rd_free_way 0, rd_all_valid 0, FSM IDLE, flush pointer 0, flush_busy 0, flush_done 0. Reset overrides every other input, including mid-flush (flush aborted, array fully cleared anyway).
- Write: at posedge with wr_en = 1 and flush_busy = 0, bit[wr_set][wr_way] <= wr_val. Other bits unchanged. wr_en during flush_busy = 1 is dropped silently.
- Read: at posedge with rd_en = 1, rd_valid/rd_free_way/rd_all_valid load from set rd_set; 1-cycle latency. rd_en = 0 holds all three outputs.
- Same-edge write and read to the same set: write is forwarded; rd_valid reflects the post-write vector.
- Read while flush_busy = 1: rd_valid loads all-zero, rd_free_way 0, rd_all_valid 0.
- rd_free_way: priority to lowest index. If all ways valid: rd_free_way = 0, rd_all_valid = 1.
- FSM states IDLE, CLEAR, DONE:
  IDLE: flush_req = 1 at edge N -> CLEAR, ptr <= 0, flush_busy <= 1.
  CLEAR: each edge clears all ways of set ptr, ptr <= ptr + 1; at the edge clearing set NUM_SETS-1 -> DONE, flush_busy <= 0, flush_done <= 1. Sets cleared at edges N+1..N+NUM_SETS.
  DONE: one cycle; next edge -> IDLE, flush_done <= 0.
- flush_req in CLEAR or DONE ignored (not queued); held high in IDLE after DONE starts a new flush.
- Writes accepted again in the DONE cycle (flush_busy = 0).
- ptr never wraps past NUM_SETS-1; no out-of-range access.

Decomposition:
- Shared cache parameter package/header: NUM_SETS/NUM_WAYS defaults (shared with tag/data arrays), FSM state encodings (IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2).
- One sub-module: first_zero_enc (parametrised NUM_WAYS priority encoder -> free index + all-ones flag), combinational, registered in the parent.

Test Plan:
- Reset then rd_en set 5 -> rd_valid = 4'b0000, rd_free_way = 0, rd_all_valid = 0.
- Write set 3 ways 0,1,2 with wr_val = 1, read set 3 -> rd_valid = 4'b0111, rd_free_way = 3; write way 3, read -> 4'b1111, rd_free_way = 0, rd_all_valid = 1.
- Same-edge wr_en set 7 way 2 val 1 with rd_en set 7 (previously 4'b0001) -> next cycle rd_valid = 4'b0101, rd_free_way = 1.
- Fill all sets, pulse flush_req at edge N -> flush_busy high cycles N+1..N+16, flush_done high exactly one cycle after edge N+16; write attempted mid-flush dropped; all 16 reads afterward return 4'b0000.
- Read during flush_busy -> rd_valid = 0; flush_req pulsed during CLEAR -> no second flush, done pulses once.
- Assert reset at edge N+5 of a flush -> flush_busy 0, flush_done never pulses, FSM IDLE, all sets read 0.
